// File: rtl/dot4_ctrl.sv
// Dot-product sequencer: feeds operand pairs one at a time to an external
// multiplier, accumulates the 8-bit products and presents the 12-bit sum.
module dot4_ctrl #(
  parameter int VEC_LEN = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  output logic        mul_st,
  output logic [3:0]  mul_mplier,
  output logic [3:0]  mul_mcand,
  input  logic [8:0]  mul_prod,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_OUT
  } state_e;

  // The counter reaches TIMEOUT on the edge that ends the TIMEOUT-th WAIT cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] LEN       = 5'(VEC_LEN);

  state_e      state_q, state_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  opb_q, opb_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  prod_q, prod_d;
  logic [11:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        unused_prod_msb;

  // A 4x4 product never sets bit 8.
  assign unused_prod_msb = mul_prod[8];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    wcnt_d    = wcnt_q;
    prod_d    = prod_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    mul_st    = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_st  = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        // A done level left over from the previous product is still visible
        // in the first WAIT cycle, so it is ignored there.
        if (wcnt_q != 8'd0 && mul_done) begin
          prod_d  = mul_prod[7:0];
          state_d = S_ACCUM;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        sum_d   = sum_q + {4'b0000, prod_q};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_d == LEN) ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      wcnt_q  <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wcnt_q  <= wcnt_d;
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mul_mplier = opa_q;
  assign mul_mcand  = opb_q;
  assign out_sum    = (state_q == S_OUT) ? sum_q : 12'd0;
  assign err        = err_q;

endmodule
